// File: rtl/bunch_train_capture_pkg.sv
// Shared definitions for the bunch-train capture block and the mask playback block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bunch_train_capture_pkg;

    // Bunch positions in one LHC orbit; the mask playback block sizes its table from this too.
    localparam int BUNCH_POS_DEFAULT = 3564;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_SYNC,
        ST_ACCUM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bc_count_ram.sv
// Simple dual-port synchronous RAM holding {mask, count} per bunch position.
// Latency: write lands on the clock edge; read data registered, 1 cycle after the address.
// Backpressure: none; one write and one read per cycle, read-before-write on the same address.
//
// Ports: clk; wr_vld/wr_addr/wr_dat write port; rd_addr in, rd_dat out (registered).
module bc_count_ram #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 9,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_vld,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/bunch_train_capture.sv
// Accumulates per-BC hit occupancy over N_ORBITS orbits and thresholds it into a fill mask.
// Latency: done rises N_ORBITS*BUNCH_POS+1 cycles after the accepted orbit_sync; readback 1 cycle.
// Backpressure: none; hit/orbit_sync are consumed every cycle, start is ignored while busy.
//
// Ports: clk, rst (sync, active-high); start pulse; orbit_sync/hit live BC stream;
//        rd_addr -> rd_mask/rd_count (valid only while done); busy, done, sticky sync_err;
//        filled_count = number of mask bits set by the last capture.
module bunch_train_capture
    import bunch_train_capture_pkg::*;
#(
    parameter int BUNCH_POS = BUNCH_POS_DEFAULT,
    parameter int N_ORBITS  = 16,
    parameter int CNT_W     = 8,
    parameter int THRESHOLD = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           orbit_sync,
    input  logic                           hit,
    input  logic [$clog2(BUNCH_POS)-1:0]   rd_addr,
    output logic                           rd_mask,
    output logic [CNT_W-1:0]               rd_count,
    output logic                           busy,
    output logic                           done,
    output logic                           sync_err,
    output logic [$clog2(BUNCH_POS+1)-1:0] filled_count
);

    localparam int POS_W = $clog2(BUNCH_POS);
    // One extra code so the orbit counter can step past the last orbit without wrapping.
    localparam int ORB_W = $clog2(N_ORBITS + 1);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BUNCH_POS - 1);
    localparam logic [ORB_W-1:0] ORB_LAST = ORB_W'(N_ORBITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);

    state_t state_q;
    state_t state_nxt;

    logic [POS_W-1:0] pos_q;       // position of the next BC while in ACCUM
    logic [ORB_W-1:0] orb_q;       // orbit of the next BC while in ACCUM
    logic [POS_W-1:0] clr_addr_q;
    logic             drain_q;     // last BC sampled; its write lands this cycle

    // Accumulate pipeline: read issued in cycle t, write of count+hit in t+1.
    logic             acc_vld_q;
    logic [POS_W-1:0] acc_addr_q;
    logic             acc_hit_q;
    logic             acc_last_q;
    logic             rd_vld_q;

    logic [POS_W-1:0] cur_pos;
    logic [ORB_W-1:0] cur_orb;
    logic             acc_rd;
    logic             acc_end;
    logic             sync_mis;
    logic             orb_over;
    logic             clear_enter;

    logic             ram_wr_vld;
    logic [POS_W-1:0] ram_wr_addr;
    logic [CNT_W:0]   ram_wr_dat;
    logic [POS_W-1:0] ram_rd_addr;
    logic [CNT_W:0]   ram_rd_dat;

    logic [CNT_W-1:0] old_cnt;
    logic [CNT_W-1:0] new_cnt;
    logic             new_mask;

    // Position/orbit of the BC on the wire this cycle, and whether it is to be counted.
    always_comb begin
        cur_pos  = pos_q;
        cur_orb  = orb_q;
        acc_rd   = 1'b0;
        acc_end  = 1'b0;
        sync_mis = 1'b0;
        orb_over = 1'b0;
        if (state_q == ST_WAIT_SYNC) begin
            cur_pos = '0;
            cur_orb = '0;
            acc_rd  = orbit_sync;
        end else if (state_q == ST_ACCUM && !drain_q) begin
            acc_rd = 1'b1;
            if (orbit_sync && pos_q != '0) begin
                // Early sync starts a new orbit on this very cycle.
                sync_mis = 1'b1;
                cur_pos  = '0;
                if (orb_q == ORB_LAST) begin
                    // It would open an orbit beyond the capture window: finish instead.
                    acc_rd   = 1'b0;
                    orb_over = 1'b1;
                end else begin
                    cur_orb = orb_q + 1'b1;
                end
            end
            acc_end = acc_rd && cur_pos == POS_LAST && cur_orb == ORB_LAST;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        clear_enter = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    state_nxt   = ST_CLEAR;
                    clear_enter = 1'b1;
                end
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_addr_q == POS_LAST) begin
                    state_nxt = ST_WAIT_SYNC;
                end
            end
            ST_WAIT_SYNC: begin
                busy = 1'b1;
                if (orbit_sync) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                busy = 1'b1;
                if (drain_q || orb_over) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign old_cnt  = ram_rd_dat[CNT_W-1:0];
    assign new_cnt  = (acc_hit_q && old_cnt != CNT_MAX) ? old_cnt + 1'b1 : old_cnt;
    assign new_mask = acc_last_q && (new_cnt >= THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q        <= '0;
            orb_q        <= '0;
            clr_addr_q   <= '0;
            drain_q      <= 1'b0;
            acc_vld_q    <= 1'b0;
            acc_addr_q   <= '0;
            acc_hit_q    <= 1'b0;
            acc_last_q   <= 1'b0;
            rd_vld_q     <= 1'b0;
            sync_err     <= 1'b0;
            filled_count <= '0;
        end else begin
            acc_vld_q  <= acc_rd;
            acc_addr_q <= cur_pos;
            acc_hit_q  <= hit;
            acc_last_q <= (cur_orb == ORB_LAST);
            drain_q    <= acc_end;
            rd_vld_q   <= (state_q == ST_DONE);
            if (acc_rd) begin
                if (cur_pos == POS_LAST) begin
                    pos_q <= '0;
                    orb_q <= cur_orb + 1'b1;
                end else begin
                    pos_q <= cur_pos + 1'b1;
                    orb_q <= cur_orb;
                end
            end
            if (state_q == ST_CLEAR) begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
            if (clear_enter) begin
                clr_addr_q   <= '0;
                sync_err     <= 1'b0;
                filled_count <= '0;
            end else begin
                if (sync_mis) begin
                    sync_err <= 1'b1;
                end
                if (acc_vld_q && new_mask) begin
                    filled_count <= filled_count + 1'b1;
                end
            end
        end
    end

    assign ram_wr_vld  = (state_q == ST_CLEAR) || acc_vld_q;
    assign ram_wr_addr = (state_q == ST_CLEAR) ? clr_addr_q : acc_addr_q;
    assign ram_wr_dat  = (state_q == ST_CLEAR) ? '0 : {new_mask, new_cnt};
    // The read port belongs to user readback only in DONE; otherwise it feeds the accumulator.
    assign ram_rd_addr = (state_q == ST_DONE) ? rd_addr : cur_pos;

    bc_count_ram #(
        .DEPTH (BUNCH_POS),
        .WIDTH (CNT_W + 1)
    ) u_ram (
        .clk     (clk),
        .wr_vld  (ram_wr_vld),
        .wr_addr (ram_wr_addr),
        .wr_dat  (ram_wr_dat),
        .rd_addr (ram_rd_addr),
        .rd_dat  (ram_rd_dat)
    );

    // Data is only meaningful if the address was presented in DONE and we are still in DONE.
    assign rd_mask  = (rd_vld_q && state_q == ST_DONE) ? ram_rd_dat[CNT_W] : 1'b0;
    assign rd_count = (rd_vld_q && state_q == ST_DONE) ? ram_rd_dat[CNT_W-1:0] : '0;

endmodule

// File: tb/tb_bunch_train_capture.sv
// Randomized bench for bunch_train_capture: two instances (normal and narrow-counter)
// driven with per-orbit hit tables; expected counts/mask/fill computed from the tables.
module tb_bunch_train_capture;

    localparam int BP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s   [2];
    logic       sync_s    [2];
    logic       hit_s     [2];
    logic [2:0] rd_addr_s [2];

    logic       busy_a, done_a, serr_a, mask_a;
    logic [7:0] cnt_a;
    logic [3:0] fill_a;
    logic       busy_b, done_b, serr_b, mask_b;
    logic [1:0] cnt_b;
    logic [3:0] fill_b;

    int n_orb [2] = '{4, 6};
    int cmax  [2] = '{255, 3};
    int thr   [2] = '{3, 3};

    int hit_tab [8][BP];
    int len     [8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bunch_train_capture #(.BUNCH_POS(BP), .N_ORBITS(4), .CNT_W(8), .THRESHOLD(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .orbit_sync(sync_s[0]), .hit(hit_s[0]),
        .rd_addr(rd_addr_s[0]), .rd_mask(mask_a), .rd_count(cnt_a), .busy(busy_a),
        .done(done_a), .sync_err(serr_a), .filled_count(fill_a));

    bunch_train_capture #(.BUNCH_POS(BP), .N_ORBITS(6), .CNT_W(2), .THRESHOLD(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .orbit_sync(sync_s[1]), .hit(hit_s[1]),
        .rd_addr(rd_addr_s[1]), .rd_mask(mask_b), .rd_count(cnt_b), .busy(busy_b),
        .done(done_b), .sync_err(serr_b), .filled_count(fill_b));

    function automatic logic [31:0] busy_o(input int d); return (d == 0) ? 32'(busy_a) : 32'(busy_b); endfunction
    function automatic logic [31:0] done_o(input int d); return (d == 0) ? 32'(done_a) : 32'(done_b); endfunction
    function automatic logic [31:0] serr_o(input int d); return (d == 0) ? 32'(serr_a) : 32'(serr_b); endfunction
    function automatic logic [31:0] mask_o(input int d); return (d == 0) ? 32'(mask_a) : 32'(mask_b); endfunction
    function automatic logic [31:0] cnt_o (input int d); return (d == 0) ? 32'(cnt_a)  : 32'(cnt_b);  endfunction
    function automatic logic [31:0] fill_o(input int d); return (d == 0) ? 32'(fill_a) : 32'(fill_b); endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_random(input int prob);
        for (int o = 0; o < 8; o++) begin
            len[o] = BP;
            for (int p = 0; p < BP; p++) hit_tab[o][p] = ($urandom_range(0, 99) < prob) ? 1 : 0;
        end
    endtask

    task automatic check_idle_outputs(input int d, input string what);
        check($sformatf("%s busy dut%0d", what, d), busy_o(d), 0);
        check($sformatf("%s done dut%0d", what, d), done_o(d), 0);
        check($sformatf("%s sync_err dut%0d", what, d), serr_o(d), 0);
        check($sformatf("%s filled dut%0d", what, d), fill_o(d), 0);
        check($sformatf("%s rd_mask dut%0d", what, d), mask_o(d), 0);
        check($sformatf("%s rd_count dut%0d", what, d), cnt_o(d), 0);
    endtask

    // One full capture from IDLE/DONE using hit_tab/len; orbits shorter than BP
    // produce an early orbit_sync at the DUT's position len[o].
    task automatic do_capture(input int d, input bit start_mid);
        int exp_cnt [BP];
        bit exp_mask [BP];
        int exp_fill = 0;
        int total = 0;
        bit exp_serr = 0;
        int off;
        int a;
        for (int p = 0; p < BP; p++) exp_cnt[p] = 0;
        for (int o = 0; o < n_orb[d]; o++) begin
            if (o < n_orb[d] - 1 && len[o] != BP) exp_serr = 1;
            for (int p = 0; p < len[o]; p++) begin
                exp_cnt[p] += hit_tab[o][p];
                total++;
            end
        end
        for (int p = 0; p < BP; p++) begin
            if (exp_cnt[p] > cmax[d]) exp_cnt[p] = cmax[d];
            exp_mask[p] = (p < len[n_orb[d] - 1]) && (exp_cnt[p] >= thr[d]);
            if (exp_mask[p]) exp_fill++;
        end

        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        check("busy after start", busy_o(d), 1);
        check("done after start", done_o(d), 0);
        check("sync_err cleared by start", serr_o(d), 0);
        check("filled cleared by start", fill_o(d), 0);
        check("rd_count zero after start", cnt_o(d), 0);
        // CLEAR: syncs here must be ignored.
        repeat (BP) begin
            sync_s[d] = 1'($urandom_range(0, 1));
            hit_s[d]  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        sync_s[d] = 1'b0;
        check("busy in wait_sync", busy_o(d), 1);
        repeat ($urandom_range(0, 3)) begin
            hit_s[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        for (int o = 0; o < n_orb[d]; o++) begin
            for (int p = 0; p < len[o]; p++) begin
                sync_s[d]  = (p == 0);
                hit_s[d]   = 1'(hit_tab[o][p]);
                start_s[d] = start_mid && o == 1 && p == 2;
                @(negedge clk);
            end
        end
        start_s[d] = 1'b0;
        sync_s[d]  = 1'b0;
        hit_s[d]   = 1'($urandom_range(0, 1));
        check($sformatf("done not early (T0+%0d)", total), done_o(d), 0);
        check("busy before done", busy_o(d), 1);
        @(negedge clk);
        check($sformatf("done at T0+%0d", total + 1), done_o(d), 1);
        check("busy cleared at done", busy_o(d), 0);
        check($sformatf("filled_count dut%0d", d), fill_o(d), 32'(exp_fill));
        check("sync_err at done", serr_o(d), 32'(exp_serr));

        off = $urandom_range(0, BP - 1);
        for (int i = 0; i < BP; i++) begin
            a = (i + off) % BP;
            rd_addr_s[d] = 3'(a);
            hit_s[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("rd_count[%0d] dut%0d", a, d), cnt_o(d), 32'(exp_cnt[a]));
            check($sformatf("rd_mask[%0d] dut%0d", a, d), mask_o(d), 32'(exp_mask[a]));
        end
        check("sync_err sticky", serr_o(d), 32'(exp_serr));
        check("still done after readback", done_o(d), 1);
    endtask

    // Abort a capture that has a misaligned sync and saturating activity, with start held during rst.
    task automatic reset_mid_accum();
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (BP + 1) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            sync_s[0] = (c == 0) || (c == 8) || (c == 11);
            hit_s[0]  = 1'b1;
            @(negedge clk);
        end
        sync_s[0] = 1'b0;
        check("sync_err on misaligned sync", serr_o(0), 1);
        rst = 1'b1;
        start_s[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_s[0] = 1'b0;
        check_idle_outputs(0, "after mid-accum rst");
        @(negedge clk);
        check("rst beats start", busy_o(0), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            sync_s[d] = 1'b0;
            hit_s[d] = 1'b0;
            rd_addr_s[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset");

        // Basic fill pattern 1,0,1,1,0,0,0,0 every orbit.
        fill_random(0);
        for (int o = 0; o < 8; o++) begin
            hit_tab[o][0] = 1; hit_tab[o][2] = 1; hit_tab[o][3] = 1;
        end
        do_capture(0, 1'b0);

        // Threshold edge: BC5 in 3 orbits, BC6 in 2 orbits (start issued from DONE).
        fill_random(0);
        for (int o = 0; o < 3; o++) hit_tab[o][5] = 1;
        for (int o = 0; o < 2; o++) hit_tab[o][6] = 1;
        do_capture(0, 1'b0);

        // Random activity at several densities; one with start pulsed during ACCUM.
        fill_random(50);
        do_capture(0, 1'b1);
        fill_random(80);
        do_capture(0, 1'b0);

        // Early orbit_sync at position 6 of orbit 1, then a clean capture clears sync_err.
        fill_random(60);
        len[1] = 6;
        do_capture(0, 1'b0);
        fill_random(70);
        do_capture(0, 1'b0);

        reset_mid_accum();
        fill_random(40);
        do_capture(0, 1'b0);

        // Narrow counter: saturation with hit held high, then random activity.
        for (int o = 0; o < 8; o++) begin
            len[o] = BP;
            for (int p = 0; p < BP; p++) hit_tab[o][p] = 1;
        end
        do_capture(1, 1'b0);
        fill_random(55);
        do_capture(1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
